// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-addressed big-endian data memory with wait states,
//               sign/zero extension and alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              R,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       di,
    output logic [31:0]       do_data,
    output logic              busy,
    output logic              done,
    output logic              align_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0]      c_WAIT  = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [7:0] Mem [0:DEPTH-1];

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [1:0]        r_size;
    logic              r_sign_ext;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_di;
    logic              r_err;

    logic              w_accept;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0]        w_b0, w_b1, w_b2, w_b3;
    logic [31:0]       w_rdata;

    assign w_accept   = (r_state == S_IDLE) && req;
    assign w_misalign = (size == 2'b11) ||
                        ((size == 2'b01) && addr[0]) ||
                        ((size == 2'b10) && (addr[1:0] != 2'b00));

    // Aligned accesses stay inside one 4-byte group, so OR-ing lane offsets
    // into the base address never crosses the end of memory.
    assign w_a0 = ADDR_W'({1'b0, r_addr} % c_DEPTH);
    assign w_a1 = w_a0 | ADDR_W'(1);
    assign w_a2 = w_a0 | ADDR_W'(2);
    assign w_a3 = w_a0 | ADDR_W'(3);

    assign w_b0 = Mem[w_a0];
    assign w_b1 = Mem[w_a1];
    assign w_b2 = Mem[w_a2];
    assign w_b3 = Mem[w_a3];

    always_comb begin
        w_rdata = {w_b0, w_b1, w_b2, w_b3};
        case (r_size)
            2'b00:   w_rdata = {{24{r_sign_ext & w_b0[7]}}, w_b0};
            2'b01:   w_rdata = {{16{r_sign_ext & w_b0[7]}}, w_b0, w_b1};
            default: w_rdata = {w_b0, w_b1, w_b2, w_b3};
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_misalign)
                        w_next = S_DONE;
                    else if (c_WAIT == 4'd0)
                        w_next = S_ACCESS;
                    else
                        w_next = S_WAIT;
                end
            end
            S_WAIT:   if (r_cnt <= 4'd1) w_next = S_ACCESS;
            S_ACCESS: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered off the DONE state, so they appear the
    // cycle after DONE is entered, while the FSM is already back in IDLE.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rw       <= 1'b0;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_addr     <= '0;
            r_di       <= 32'd0;
            r_err      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            align_err  <= 1'b0;
            do_data    <= 32'd0;
        end else begin
            r_state   <= w_next;
            done      <= (r_state == S_DONE);
            align_err <= (r_state == S_DONE) && r_err;
            if (w_accept) begin
                r_rw       <= rw;
                r_size     <= size;
                r_sign_ext <= sign_ext;
                r_addr     <= addr;
                r_di       <= di;
                r_err      <= w_misalign;
                r_cnt      <= c_WAIT;
                busy       <= 1'b1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_DONE)
                busy <= 1'b0;
            if ((r_state == S_ACCESS) && !r_rw)
                do_data <= w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_ACCESS) && r_rw) begin
            case (r_size)
                2'b00: Mem[w_a0] <= r_di[7:0];
                2'b01: begin
                    Mem[w_a0] <= r_di[15:8];
                    Mem[w_a1] <= r_di[7:0];
                end
                2'b10: begin
                    Mem[w_a0] <= r_di[31:24];
                    Mem[w_a1] <= r_di[23:16];
                    Mem[w_a2] <= r_di[15:8];
                    Mem[w_a3] <= r_di[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl (WAIT_STATES 1 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        R   = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        sign_ext = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] di = 32'd0;
    logic [31:0] do0, do1;
    logic        busy0, busy1, done0, done1, err0, err1;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  ref_mem [2][256];
    logic [31:0] ref_do  [2];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .R(R), .req(req1), .rw(rw), .size(size), .sign_ext(sign_ext),
        .addr(addr), .di(di), .do_data(do1), .busy(busy1), .done(done1), .align_err(err1)
    );

    data_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .R(R), .req(req0), .rw(rw), .size(size), .sign_ext(sign_ext),
        .addr(addr), .di(di), .do_data(do0), .busy(busy0), .done(done0), .align_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit s, input logic v);
        if (s) req1 = v; else req0 = v;
    endtask

    task automatic poke(input bit s, input int a, input logic [7:0] v);
        if (s) u_dut1.Mem[a] = v; else u_dut0.Mem[a] = v;
        ref_mem[s][a] = v;
    endtask

    function automatic logic [7:0] peek(input bit s, input int a);
        return s ? u_dut1.Mem[a] : u_dut0.Mem[a];
    endfunction

    function automatic bit is_misaligned(input int sz, input int a);
        return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    endfunction

    // Reference read: gather bytes MSB-first, then extend from the top bit.
    function automatic logic [31:0] ref_read(input bit s, input int a, input int sz, input bit sx);
        logic [31:0] v = 32'd0;
        int nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[s][(a + i) % 256]);
        if (sx && nb < 4 && ((v >> (8 * nb - 1)) & 32'd1) != 0)
            v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    task automatic ref_write(input bit s, input int a, input int sz, input logic [31:0] d);
        int nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        for (int i = 0; i < nb; i++)
            ref_mem[s][(a + i) % 256] = 8'((d >> (8 * (nb - 1 - i))) & 32'hFF);
    endtask

    // One transaction: request, measure latency, check result, check pulse.
    task automatic op(input bit s, input bit w, input logic [1:0] sz, input bit sx,
                      input logic [7:0] a, input logic [31:0] d, input bit extra);
        int  n = 0;
        bit  got = 0;
        bit  mis = is_misaligned(int'(sz), int'(a));
        int  exp_lat = mis ? 1 : (s ? 3 : 2);
        int  stray = 0;
        @(negedge clk);
        rw = w; size = sz; sign_ext = sx; addr = a; di = d;
        set_req(s, 1'b1);
        @(posedge clk); #1;
        chk("busy_after_accept", 32'(s ? busy1 : busy0), 32'd1);
        @(negedge clk);
        set_req(s, extra);
        do begin
            @(posedge clk); #1;
            n++;
            got = s ? done1 : done0;
            if (!got) begin
                @(negedge clk);
                set_req(s, 1'b0);
            end
        end while (!got && n < 40);
        set_req(s, 1'b0);
        if (!mis) begin
            if (w) ref_write(s, int'(a), int'(sz), d);
            else   ref_do[s] = ref_read(s, int'(a), int'(sz), sx);
        end
        chk("done_latency", 32'(n), 32'(exp_lat));
        chk("busy_at_done", 32'(s ? busy1 : busy0), 32'd0);
        chk("align_err", 32'(s ? err1 : err0), 32'(mis));
        chk("do_data", s ? do1 : do0, ref_do[s]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if ((s ? done1 : done0) !== 1'b0) stray++;
        end
        chk("single_done_pulse", 32'(stray), 32'd0);
    endtask

    initial begin
        int mism;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) poke(s[0], i, 8'($urandom));
        ref_do[0] = 32'd0;
        ref_do[1] = 32'd0;

        // Reset: a request held during the reset edge must not be taken.
        req1 = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_do1", do1, 32'd0);
        chk("rst_do0", do0, 32'd0);
        @(negedge clk);
        req1 = 1'b0;
        R = 1'b0;

        // Word read, big-endian.
        poke(1, 52, 8'h80); poke(1, 53, 8'h00); poke(1, 54, 8'h00); poke(1, 55, 8'h05);
        op(1, 0, 2'b10, 0, 8'd52, 32'd0, 0);
        chk("word_read_const", do1, 32'h80000005);

        // Signed / unsigned byte read.
        poke(1, 56, 8'hF0);
        op(1, 0, 2'b00, 1, 8'd56, 32'd0, 0);
        chk("sbyte_const", do1, 32'hFFFFFFF0);
        op(1, 0, 2'b00, 0, 8'd56, 32'd0, 0);
        chk("ubyte_const", do1, 32'h000000F0);

        // Byte write leaves neighbours alone.
        op(1, 1, 2'b00, 0, 8'd58, 32'h123456AB, 0);
        chk("bw_mem58", 32'(peek(1, 58)), 32'h000000AB);
        chk("bw_mem57", 32'(peek(1, 57)), 32'(ref_mem[1][57]));
        chk("bw_mem59", 32'(peek(1, 59)), 32'(ref_mem[1][59]));
        op(1, 0, 2'b10, 0, 8'd56, 32'd0, 0);
        chk("bw_readback_b2", 32'(do1[15:8]), 32'h000000AB);

        // Misaligned word read and reserved size.
        op(1, 0, 2'b10, 0, 8'd53, 32'd0, 0);
        op(1, 1, 2'b11, 0, 8'd40, 32'hCAFEF00D, 0);
        op(1, 1, 2'b01, 0, 8'd61, 32'h0000BEEF, 1);

        // WAIT_STATES=0 instance, with a stray req pulse while busy.
        op(0, 0, 2'b10, 0, 8'd8, 32'd0, 1);
        op(0, 1, 2'b01, 0, 8'd10, 32'h00008001, 1);
        op(0, 0, 2'b01, 1, 8'd10, 32'd0, 0);

        // Reset during WAIT of a word write must leave memory untouched.
        @(negedge clk);
        rw = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 8'd0; di = 32'hDEADBEEF;
        req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        chk("midrst_busy_pre", 32'(busy1), 32'd1);
        #2 R = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_done", 32'(done1), 32'd0);
        chk("midrst_err", 32'(err1), 32'd0);
        chk("midrst_do", do1, 32'd0);
        @(negedge clk);
        R = 1'b0;
        ref_do[0] = 32'd0;
        ref_do[1] = 32'd0;
        for (int i = 0; i < 4; i++) chk("midrst_mem", 32'(peek(1, i)), 32'(ref_mem[1][i]));
        op(1, 0, 2'b10, 0, 8'd0, 32'd0, 0);

        // Randomized traffic on both instances.
        for (int k = 0; k < 40; k++)
            op(1, 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
               $urandom, 1'($urandom));
        for (int k = 0; k < 20; k++)
            op(0, 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
               $urandom, 1'($urandom));

        for (int s = 0; s < 2; s++) begin
            mism = 0;
            for (int i = 0; i < 256; i++)
                if (peek(s[0], i) !== ref_mem[s][i]) mism++;
            chk(s ? "mem_image1" : "mem_image0", 32'(mism), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
